cnn_window_feeder: RTL
======================

// Module: cnn_window_feeder
// PURPOSE
//  Upstream stage of the CNN core. Accepts one 28x28 8-bit image as a raster pixel
//  stream and stores it in an internal frame buffer. Then sweeps every 5x5 window
//  (24x24 positions) into the core on IMGIN with the X/Y/START timing the core needs.
//  Captures the core's DONE/OUT class result and re-arms for the next frame.
// PARAMETERS
//  IMG_W    28   image width and height in pixels (square image)
//  K         5   kernel size; OUT_DIM = IMG_W-K+1 = 24, which must be <= 32 (5-bit X/Y)
//  PIX_W     8   pixel width in bits; IMGIN width = K*K*PIX_W = 200
// PORTS
//  CLK        in   1    clock, rising edge
//  nRST       in   1    asynchronous active-low reset
//  PIX_VALID  in   1    PIX_IN holds a valid pixel
//  PIX_IN     in   8    pixel value, raster order: p = r*IMG_W + c
//  PIX_READY  out  1    combinational; 1 only in LOAD
//  START      out  1    registered; one-cycle pulse to the core
//  X          out  5    registered window row (top-left row of the current window)
//  Y          out  5    registered window column
//  IMGIN      out  200  registered window: IMGIN[(i*5+j)*8 +: 8] = pix(row+i, col+j)
//  CNN_DONE   in   1    core result strobe
//  CNN_OUT    in   4    core class result, valid when CNN_DONE=1
//  RES_VALID  out  1    registered; one-cycle pulse when RES updates
//  RES        out  4    last captured class; holds value between frames
// BEHAVIOUR
//  - Reset values: START=0, X=0, Y=0, IMGIN=0, RES_VALID=0, RES=0.
//    State after reset is LOAD with pixel count 0. Reset at any time, including
//    mid-load or mid-sweep, discards the partial frame and returns to LOAD.
//    Frame buffer contents are not cleared.
//  - LOAD: a pixel is accepted on an edge where PIX_VALID && PIX_READY.
//    Pixel k is written to buffer[k]. Gaps in PIX_VALID are allowed.
//    On acceptance of pixel 783 the next state is ISSUE.
//  - ISSUE (1 cycle): START=1, IMGIN=window(0,0), X=0, Y=0.
//  - SWEEP (576 cycles), coordinate index k = 0..575: X = k/24, Y = k%24 (Y fastest).
//    IMGIN = window(k+1), i.e. IMGIN leads X/Y by one position. This is required
//    because the core latches IMGIN one cycle before it consumes the window at X/Y.
//    At k=575 (X=23, Y=23) IMGIN = 0. START=0 throughout SWEEP.
//  - WAIT: X/Y hold at 23/23 and IMGIN=0. State stays WAIT until CNN_DONE=1.
//    On that edge RES<=CNN_OUT and RES_VALID<=1 for exactly one cycle.
//    Next state is LOAD, so PIX_READY=1 in the following cycle.
//  - CNN_DONE outside WAIT is ignored. PIX_VALID outside LOAD is ignored
//    (PIX_READY=0, no write, no count change). WAIT has no timeout.
//  - Window read: 25 buffer reads per cycle. Address = (row+i)*IMG_W + (col+j),
//    using 10-bit address arithmetic; row+i never exceeds 27.
//  - Latency: 784th pixel accepted at edge E -> START high in the cycle after E.
//    The first SWEEP cycle (X=0, Y=0) follows 1 cycle later.
//    Last SWEEP cycle ends 577 cycles after START rises.
// TESTING
//  1. Assert nRST low mid-cycle with CLK stopped -> START/X/Y/IMGIN/RES/RES_VALID=0
//     immediately; PIX_READY=1 after release.
//  2. Stream ramp image pix(r,c)=(r*28+c)%256 with PIX_VALID always 1 -> START pulse
//     the cycle after pixel 783. IMGIN byte0=0, byte4=4, byte5=28, byte24=116.
//  3. Continue the sweep -> at X=0,Y=0: IMGIN byte0=1. At X=0,Y=23: byte0=28
//     (window(1,0)). Exactly 576 SWEEP cycles; last is X=23,Y=23 with IMGIN=0.
//  4. Random PIX_VALID gaps during LOAD, then PIX_VALID=1 during SWEEP/WAIT ->
//     buffer matches stream order; no pixels accepted outside LOAD.
//  5. In WAIT, hold CNN_DONE low 20 cycles, then pulse with CNN_OUT=7 -> RES=7,
//     one-cycle RES_VALID, PIX_READY=1 next cycle. A second frame sweeps correctly.
//  6. Assert reset at SWEEP k=300 -> outputs reset, state LOAD. Reload a full frame ->
//     START re-issued and full 576-cycle sweep with RES unchanged until the next CNN_DONE.

Source files
------------

// File: rtl/cnn_window_feeder_if.sv
// Handshake and window bus between the pixel source, the window feeder and the CNN core.
interface cnn_window_feeder_if #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
);
  logic                 PIX_VALID;
  logic [PIX_W-1:0]     PIX_IN;
  logic                 PIX_READY;
  logic                 START;
  logic [4:0]           X;
  logic [4:0]           Y;
  logic [K*K*PIX_W-1:0] IMGIN;
  logic                 CNN_DONE;
  logic [3:0]           CNN_OUT;
  logic                 RES_VALID;
  logic [3:0]           RES;

  modport master (
    output PIX_VALID, PIX_IN, CNN_DONE, CNN_OUT,
    input  PIX_READY, START, X, Y, IMGIN, RES_VALID, RES
  );

  modport slave (
    input  PIX_VALID, PIX_IN, CNN_DONE, CNN_OUT,
    output PIX_READY, START, X, Y, IMGIN, RES_VALID, RES
  );
endinterface

// File: rtl/cnn_window_feeder.sv
// Buffers one raster image, then streams every KxK window into the CNN core and
// captures the class result it returns.
module cnn_window_feeder #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
) (
  input logic                CLK,
  input logic                nRST,
  cnn_window_feeder_if.slave bus
);
  localparam int AW      = 10;
  localparam int OUT_DIM = IMG_W - K + 1;
  localparam int NPIX    = IMG_W * IMG_W;
  localparam int WIN_W   = K * K * PIX_W;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW-1:0] LAST_POS = AW'(OUT_DIM * OUT_DIM - 1);
  localparam logic [4:0]    LAST_RC  = 5'(OUT_DIM - 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_SWEEP, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     pix_cnt;
  logic [AW-1:0]     sweep_k;
  logic [4:0]        rd_row, rd_col, nxt_row, nxt_col;
  logic              rd_vld, nxt_vld;
  logic              start_q, res_vld_q;
  logic [4:0]        x_q, y_q;
  logic [WIN_W-1:0]  img_q;
  logic [3:0]        res_q;
  logic [PIX_W-1:0]  buf_mem [NPIX];
  logic [WIN_W-1:0]  win;
  logic              accept, sweep_last;

  assign accept     = bus.PIX_VALID && (state_q == S_LOAD);
  assign sweep_last = (sweep_k == LAST_POS);

  assign bus.PIX_READY = (state_q == S_LOAD);
  assign bus.START     = start_q;
  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.IMGIN     = img_q;
  assign bus.RES_VALID = res_vld_q;
  assign bus.RES       = res_q;

  // Frame buffer is deliberately left out of reset.
  always_ff @(posedge CLK)
    if (accept) buf_mem[pix_cnt] <= bus.PIX_IN;

  // rd_row/rd_col name the window that lands in IMGIN on the next edge,
  // one position ahead of X/Y.
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      logic [AW-1:0] addr;
      assign addr = (AW'(rd_row) + AW'(gi)) * AW'(IMG_W) + AW'(rd_col) + AW'(gj);
      assign win[(gi*K+gj)*PIX_W +: PIX_W] = buf_mem[addr];
    end
  end

  always_comb begin
    nxt_row = rd_row;
    nxt_col = rd_col + 5'd1;
    nxt_vld = rd_vld;
    if (rd_col == LAST_RC) begin
      nxt_col = '0;
      if (rd_row == LAST_RC) nxt_vld = 1'b0;
      else                   nxt_row = rd_row + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (accept && pix_cnt == LAST_PIX) state_d = S_ISSUE;
      S_ISSUE: state_d = S_SWEEP;
      S_SWEEP: if (sweep_last) state_d = S_WAIT;
      S_WAIT:  if (bus.CNN_DONE) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_LOAD;
      pix_cnt   <= '0;
      sweep_k   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      rd_vld    <= 1'b1;
      start_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      img_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= 1'b0;
      res_vld_q <= 1'b0;
      case (state_q)
        S_LOAD: if (accept) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_cnt == LAST_PIX) begin
            start_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            img_q   <= win;
            rd_row  <= nxt_row;
            rd_col  <= nxt_col;
            rd_vld  <= nxt_vld;
          end
        end
        S_ISSUE: begin
          sweep_k <= '0;
          img_q   <= win;
          rd_row  <= nxt_row;
          rd_col  <= nxt_col;
          rd_vld  <= nxt_vld;
        end
        S_SWEEP: if (!sweep_last) begin
          sweep_k <= sweep_k + 1'b1;
          img_q   <= rd_vld ? win : '0;
          rd_row  <= nxt_row;
          rd_col  <= nxt_col;
          rd_vld  <= nxt_vld;
          if (y_q == LAST_RC) begin
            y_q <= '0;
            x_q <= x_q + 5'd1;
          end else begin
            y_q <= y_q + 5'd1;
          end
        end
        S_WAIT: if (bus.CNN_DONE) begin
          res_q     <= bus.CNN_OUT;
          res_vld_q <= 1'b1;
          pix_cnt   <= '0;
          rd_row    <= '0;
          rd_col    <= '0;
          rd_vld    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
